stall_sink_buffer: RTL and testbench

Dual-lane receiving end of the pipeline stall handshake. It sits between the pipeline outputs and the downstream consumer, and drives the pipeline's in_stall_1/in_stall_2 inputs, which are currently tied low.
Each lane buffers valid pipeline results in a FIFO and drains them at a throttled rate. It raises per-lane backpressure before the FIFO can overflow, absorbing the pipeline's in-flight skid.

---
 rtl/stall_sink_pkg.sv | 14 +
 rtl/stall_sink_buffer_if.sv | 51 +++++
 rtl/stall_sink_lane_fifo.sv | 117 +++++++++++
 rtl/stall_sink_buffer.sv | 73 +++++++
 tb/tb_stall_sink_buffer.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stall_sink_pkg.sv
// Shared defaults, lane indices and the count type for the dual-lane stall sink buffer.
package stall_sink_pkg;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_DEPTH        = 8;
    localparam int DEF_SKID         = 2;
    localparam int DEF_DRAIN_PERIOD = 3;

    localparam int NUM_LANES = 2;
    localparam int LANE_1    = 0;
    localparam int LANE_2    = 1;

    // Occupancy needs one extra bit so that a full FIFO (count == DEPTH) is representable.
    typedef logic [$clog2(DEF_DEPTH):0] count_t;
endpackage

// File: rtl/stall_sink_buffer_if.sv
// Pipeline-side and consumer-side signals of the stall sink buffer.
// Optional stall_cycles_* counters exist only when STALL_SINK_STATS_EN is defined.
interface stall_sink_buffer_if
    import stall_sink_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic [DATA_W-1:0] in_data_1;
    logic [DATA_W-1:0] in_data_2;
    logic              in_valid_1;
    logic              in_valid_2;
    logic              flush_1;
    logic              flush_2;
    logic              sink_ready_1;
    logic              sink_ready_2;
    logic              out_stall_1;
    logic              out_stall_2;
    logic [DATA_W-1:0] out_data_1;
    logic [DATA_W-1:0] out_data_2;
    logic              out_valid_1;
    logic              out_valid_2;
    logic              overflow_1;
    logic              overflow_2;
`ifdef STALL_SINK_STATS_EN
    logic [31:0]       stall_cycles_1;
    logic [31:0]       stall_cycles_2;
`endif

    // Handshake: a word is taken whenever in_valid_k is high and the lane is not full;
    // out_stall_k asks the pipeline to stop, SKID entries stay free for words already in
    // flight. out_valid_k is a single-cycle pulse, qualified by sink_ready_k at drain time.
    modport master (
        output in_data_1, in_data_2, in_valid_1, in_valid_2,
        output flush_1, flush_2, sink_ready_1, sink_ready_2,
        input  out_stall_1, out_stall_2, out_data_1, out_data_2,
        input  out_valid_1, out_valid_2, overflow_1, overflow_2
`ifdef STALL_SINK_STATS_EN
        , input stall_cycles_1, stall_cycles_2
`endif
    );

    modport slave (
        input  in_data_1, in_data_2, in_valid_1, in_valid_2,
        input  flush_1, flush_2, sink_ready_1, sink_ready_2,
        output out_stall_1, out_stall_2, out_data_1, out_data_2,
        output out_valid_1, out_valid_2, overflow_1, overflow_2
`ifdef STALL_SINK_STATS_EN
        , output stall_cycles_1, stall_cycles_2
`endif
    );
endinterface

// File: rtl/stall_sink_lane_fifo.sv
// One lane: FIFO, throttled drain counter, registered stall, sticky overflow.
// STALL_SINK_STATS_EN adds a saturating count of stalled cycles.
module stall_sink_lane_fifo #(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 8,
    parameter int SKID         = 2,
    parameter int DRAIN_PERIOD = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    input  logic              i_flush,
    input  logic              i_sink_ready,
    output logic              o_stall,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_overflow
`ifdef STALL_SINK_STATS_EN
    , output logic [31:0]     o_stall_cycles
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = (DRAIN_PERIOD > 1) ? $clog2(DRAIN_PERIOD) : 1;

    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_AT  = CW'(DEPTH - SKID);
    localparam logic [DW-1:0] LAST_TICK = DW'(DRAIN_PERIOD - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [DW-1:0]     r_drain_cnt;
    logic              r_stall;
    logic              r_valid;
    logic              r_overflow;
    logic [DATA_W-1:0] r_data;

    logic              w_tick;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic [CW-1:0]     w_count_next;

    // Flush dominates: no push, pop or drop is taken in a flushing cycle.
    always_comb begin
        w_tick       = (r_drain_cnt == LAST_TICK);
        w_push       = i_valid && (r_count != FULL) && !i_flush;
        w_drop       = i_valid && (r_count == FULL) && !i_flush;
        w_pop        = w_tick && i_sink_ready && (r_count != '0) && !i_flush;
        w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_drain_cnt <= '0;
            r_stall     <= 1'b0;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
            r_data      <= '0;
        end else begin
            r_drain_cnt <= w_tick ? '0 : r_drain_cnt + 1'b1;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_valid  <= 1'b0;
                r_stall  <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                    r_data   <= r_mem[r_rd_ptr];
                end
                r_count <= w_count_next;
                r_valid <= w_pop;
                // Looking at count_next lets the pipeline see stall in the same cycle the threshold is hit.
                r_stall <= (w_count_next >= STALL_AT);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_stall    = r_stall;
    assign o_data     = r_data;
    assign o_valid    = r_valid;
    assign o_overflow = r_overflow;

`ifdef STALL_SINK_STATS_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cycles <= '0;
        end else if (r_stall && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
`endif
endmodule

// File: rtl/stall_sink_buffer.sv
// Dual-lane stall sink: two independent lane FIFOs that backpressure the pipeline.
// Define STALL_SINK_STATS_EN to add per-lane stall_cycles counters.
module stall_sink_buffer
    import stall_sink_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int SKID         = DEF_SKID,
    parameter int DRAIN_PERIOD = DEF_DRAIN_PERIOD
) (
    input logic          clk,
    input logic          reset,
    stall_sink_buffer_if.slave bus
);
    logic [DATA_W-1:0] w_in_data  [NUM_LANES];
    logic              w_in_valid [NUM_LANES];
    logic              w_flush    [NUM_LANES];
    logic              w_ready    [NUM_LANES];
    logic              w_stall    [NUM_LANES];
    logic [DATA_W-1:0] w_out_data [NUM_LANES];
    logic              w_out_valid[NUM_LANES];
    logic              w_overflow [NUM_LANES];

    assign w_in_data[LANE_1]  = bus.in_data_1;
    assign w_in_data[LANE_2]  = bus.in_data_2;
    assign w_in_valid[LANE_1] = bus.in_valid_1;
    assign w_in_valid[LANE_2] = bus.in_valid_2;
    assign w_flush[LANE_1]    = bus.flush_1;
    assign w_flush[LANE_2]    = bus.flush_2;
    assign w_ready[LANE_1]    = bus.sink_ready_1;
    assign w_ready[LANE_2]    = bus.sink_ready_2;

`ifdef STALL_SINK_STATS_EN
    logic [31:0] w_stall_cycles [NUM_LANES];
`endif

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        stall_sink_lane_fifo #(
            .DATA_W       (DATA_W),
            .DEPTH        (DEPTH),
            .SKID         (SKID),
            .DRAIN_PERIOD (DRAIN_PERIOD)
        ) u_lane (
            .i_clk        (clk),
            .i_rst_n      (reset),
            .i_data       (w_in_data[g]),
            .i_valid      (w_in_valid[g]),
            .i_flush      (w_flush[g]),
            .i_sink_ready (w_ready[g]),
            .o_stall      (w_stall[g]),
            .o_data       (w_out_data[g]),
            .o_valid      (w_out_valid[g]),
            .o_overflow   (w_overflow[g])
`ifdef STALL_SINK_STATS_EN
            , .o_stall_cycles (w_stall_cycles[g])
`endif
        );
    end

    assign bus.out_stall_1 = w_stall[LANE_1];
    assign bus.out_stall_2 = w_stall[LANE_2];
    assign bus.out_data_1  = w_out_data[LANE_1];
    assign bus.out_data_2  = w_out_data[LANE_2];
    assign bus.out_valid_1 = w_out_valid[LANE_1];
    assign bus.out_valid_2 = w_out_valid[LANE_2];
    assign bus.overflow_1  = w_overflow[LANE_1];
    assign bus.overflow_2  = w_overflow[LANE_2];

`ifdef STALL_SINK_STATS_EN
    assign bus.stall_cycles_1 = w_stall_cycles[LANE_1];
    assign bus.stall_cycles_2 = w_stall_cycles[LANE_2];
`endif
endmodule

// File: tb/tb_stall_sink_buffer.sv
// Bench for stall_sink_buffer: two instances (drain period 3 and 1) against a queue-based model.
// Stats checks are compiled in when STALL_SINK_STATS_EN is defined.
module tb_stall_sink_buffer;
    localparam int W     = 32;
    localparam int DEPTH = 8;
    localparam int SKID  = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // Flat lane index k: 0 = dut0 lane1, 1 = dut0 lane2, 2 = dut1 lane1, 3 = dut1 lane2.
    logic [W-1:0] drv_data  [4];
    logic         drv_valid [4];
    logic         drv_flush [4];
    logic         drv_ready [4];

    stall_sink_buffer_if #(.DATA_W(W)) bus0 ();
    stall_sink_buffer_if #(.DATA_W(W)) bus1 ();

    assign bus0.in_data_1    = drv_data[0];
    assign bus0.in_data_2    = drv_data[1];
    assign bus0.in_valid_1   = drv_valid[0];
    assign bus0.in_valid_2   = drv_valid[1];
    assign bus0.flush_1      = drv_flush[0];
    assign bus0.flush_2      = drv_flush[1];
    assign bus0.sink_ready_1 = drv_ready[0];
    assign bus0.sink_ready_2 = drv_ready[1];
    assign bus1.in_data_1    = drv_data[2];
    assign bus1.in_data_2    = drv_data[3];
    assign bus1.in_valid_1   = drv_valid[2];
    assign bus1.in_valid_2   = drv_valid[3];
    assign bus1.flush_1      = drv_flush[2];
    assign bus1.flush_2      = drv_flush[3];
    assign bus1.sink_ready_1 = drv_ready[2];
    assign bus1.sink_ready_2 = drv_ready[3];

    stall_sink_buffer #(.DATA_W(W), .DEPTH(DEPTH), .SKID(SKID), .DRAIN_PERIOD(3)) dut0 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus0.slave)
    );

    stall_sink_buffer #(.DATA_W(W), .DEPTH(DEPTH), .SKID(SKID), .DRAIN_PERIOD(1)) dut1 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus1.slave)
    );

    // ---------------- reference model ----------------
    logic [W-1:0] exp_q [4][$];
    logic         m_valid [4];
    logic         m_stall [4];
    logic         m_ovf   [4];
    logic [W-1:0] m_data  [4];
    longint       m_sc    [4];
    int           cyc     [2];
    logic [W-1:0] b_val;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            exp_q[k].delete();
            m_valid[k] = 1'b0;
            m_stall[k] = 1'b0;
            m_ovf[k]   = 1'b0;
            m_data[k]  = '0;
            m_sc[k]    = 0;
        end
        cyc[0] = 0;
        cyc[1] = 0;
    endtask

    // Edge n after reset release is a drain opportunity when n mod period == period-1.
    task automatic model_edge(input int k);
        int p;
        bit tick;
        bit pop;
        bit push;
        p    = (k < 2) ? 3 : 1;
        tick = ((cyc[k/2] % p) == p - 1);
        if (m_stall[k] && m_sc[k] != 64'hFFFF_FFFF) m_sc[k]++;
        if (drv_flush[k]) begin
            exp_q[k].delete();
            m_valid[k] = 1'b0;
            m_stall[k] = 1'b0;
        end else begin
            pop  = tick && drv_ready[k] && (exp_q[k].size() > 0);
            push = drv_valid[k] && (exp_q[k].size() < DEPTH);
            if (drv_valid[k] && exp_q[k].size() == DEPTH) m_ovf[k] = 1'b1;
            m_valid[k] = pop;
            if (pop) m_data[k] = exp_q[k].pop_front();
            if (push) exp_q[k].push_back(drv_data[k]);
            m_stall[k] = (exp_q[k].size() >= DEPTH - SKID);
        end
    endtask

    task automatic get_out(input int k, output logic v, output logic s, output logic o,
                           output logic [W-1:0] d, output logic [31:0] sc);
        sc = '0;
        case (k)
            0: begin v = bus0.out_valid_1; s = bus0.out_stall_1; o = bus0.overflow_1; d = bus0.out_data_1; end
            1: begin v = bus0.out_valid_2; s = bus0.out_stall_2; o = bus0.overflow_2; d = bus0.out_data_2; end
            2: begin v = bus1.out_valid_1; s = bus1.out_stall_1; o = bus1.overflow_1; d = bus1.out_data_1; end
            default: begin v = bus1.out_valid_2; s = bus1.out_stall_2; o = bus1.overflow_2; d = bus1.out_data_2; end
        endcase
`ifdef STALL_SINK_STATS_EN
        case (k)
            0: sc = bus0.stall_cycles_1;
            1: sc = bus0.stall_cycles_2;
            2: sc = bus1.stall_cycles_1;
            default: sc = bus1.stall_cycles_2;
        endcase
`endif
    endtask

    task automatic check_all();
        logic v, s, o;
        logic [W-1:0] d;
        logic [31:0] sc;
        for (int k = 0; k < 4; k++) begin
            get_out(k, v, s, o, d, sc);
            check_eq($sformatf("k%0d_valid", k), 64'(v), 64'(m_valid[k]));
            check_eq($sformatf("k%0d_stall", k), 64'(s), 64'(m_stall[k]));
            check_eq($sformatf("k%0d_overflow", k), 64'(o), 64'(m_ovf[k]));
            check_eq($sformatf("k%0d_data", k), 64'(d), 64'(m_data[k]));
`ifdef STALL_SINK_STATS_EN
            check_eq($sformatf("k%0d_stall_cycles", k), 64'(sc), 64'(m_sc[k]));
`endif
        end
    endtask

    // ---------------- driver tasks ----------------
    // dut1 lane2 sees a continuous push stream with sink always ready; dut1 lane1 is random.
    task automatic drive_dut1();
        drv_valid[3] = 1'b1;
        drv_data[3]  = b_val;
        drv_ready[3] = 1'b1;
        drv_flush[3] = 1'b0;
        b_val        = b_val + 1;
        drv_valid[2] = 1'($urandom_range(0, 1));
        drv_data[2]  = $urandom;
        drv_ready[2] = 1'($urandom_range(0, 1));
        drv_flush[2] = ($urandom_range(0, 30) == 0);
    endtask

    task automatic step();
        @(posedge clk);
        for (int k = 0; k < 4; k++) model_edge(k);
        cyc[0]++;
        cyc[1]++;
        #1;
        check_all();
        check_eq("p1_no_stall", 64'(bus1.out_stall_2), 64'd0);
        drive_dut1();
    endtask

    task automatic reset_dut();
        logic v, s, o;
        logic [W-1:0] d;
        logic [31:0] sc;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            get_out(k, v, s, o, d, sc);
            check_eq($sformatf("rst_k%0d_valid", k), 64'(v), 64'd0);
            check_eq($sformatf("rst_k%0d_stall", k), 64'(s), 64'd0);
            check_eq($sformatf("rst_k%0d_overflow", k), 64'(o), 64'd0);
            check_eq($sformatf("rst_k%0d_data", k), 64'(d), 64'd0);
            check_eq($sformatf("rst_k%0d_stall_cycles", k), 64'(sc), 64'd0);
        end
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rel_stall_1", 64'(bus0.out_stall_1), 64'd0);
    endtask

    task automatic idle_dut0();
        for (int k = 0; k < 2; k++) begin
            drv_valid[k] = 1'b0;
            drv_flush[k] = 1'b0;
            drv_ready[k] = 1'b0;
            drv_data[k]  = '0;
        end
    endtask

    // ---------------- main sequence ----------------
    int     pulses;
`ifdef STALL_SINK_STATS_EN
    logic [31:0] sc_mark;
`endif

    initial begin
        for (int k = 0; k < 4; k++) begin
            drv_data[k]  = '0;
            drv_valid[k] = 1'b0;
            drv_flush[k] = 1'b0;
            drv_ready[k] = 1'b0;
        end
        b_val = 32'hB0;
        model_reset();

        // Power-up reset, then load a word and reset again while in_valid_1 is held high.
        reset_dut();
        drv_valid[0] = 1'b1;
        drv_data[0]  = 32'h55;
        step();
        step();
        reset_dut();

        // Fill lane 1 with no drain: stall at 6, full at 8, drop on the 9th word.
        idle_dut0();
        for (int i = 0; i < 9; i++) begin
            drv_valid[0] = 1'b1;
            drv_data[0]  = 32'h11 + i;
            step();
            if (i == 4) check_eq("fill_nostall_at5", 64'(bus0.out_stall_1), 64'd0);
            if (i == 5) check_eq("fill_stall_at6", 64'(bus0.out_stall_1), 64'd1);
            if (i == 7) check_eq("fill_no_ovf_at8", 64'(bus0.overflow_1), 64'd0);
            if (i == 8) check_eq("fill_ovf_on_drop", 64'(bus0.overflow_1), 64'd1);
        end
        drv_valid[0] = 1'b0;
        repeat (4) step();
        check_eq("ovf_sticky", 64'(bus0.overflow_1), 64'd1);

        // Throttled drain of a full lane: one pop every third cycle, in order.
        reset_dut();
        idle_dut0();
        for (int i = 0; i < 8; i++) begin
            drv_valid[0] = 1'b1;
            drv_data[0]  = 32'hA0 + i;
            step();
        end
        drv_valid[0] = 1'b0;
        drv_ready[0] = 1'b1;
        pulses = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (bus0.out_valid_1) pulses++;
        end
        check_eq("drain_pulses", 64'(pulses), 64'd8);

        // Flush lane 1 at count 5 with a simultaneous push; lane 2 keeps its words.
        reset_dut();
        idle_dut0();
        for (int i = 0; i < 5; i++) begin
            drv_valid[0] = 1'b1;
            drv_data[0]  = 32'hC0 + i;
            drv_valid[1] = (i < 3);
            drv_data[1]  = 32'hD0 + i;
            step();
        end
        drv_valid[1] = 1'b0;
        drv_flush[0] = 1'b1;
        drv_valid[0] = 1'b1;
        drv_data[0]  = 32'hEE;
        step();
        check_eq("flush_stall", 64'(bus0.out_stall_1), 64'd0);
        check_eq("flush_valid", 64'(bus0.out_valid_1), 64'd0);
        drv_flush[0] = 1'b0;
        drv_valid[0] = 1'b0;
        drv_ready[0] = 1'b1;
        drv_ready[1] = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus0.out_valid_1) pulses++;
        end
        check_eq("flush_lane1_empty", 64'(pulses), 64'd0);

`ifdef STALL_SINK_STATS_EN
        // Stall cycle counting while full, retained across a flush.
        reset_dut();
        idle_dut0();
        for (int i = 0; i < 8; i++) begin
            drv_valid[0] = 1'b1;
            drv_data[0]  = $urandom;
            step();
        end
        drv_valid[0] = 1'b0;
        sc_mark = bus0.stall_cycles_1;
        repeat (10) step();
        check_eq("stats_plus10", 64'(bus0.stall_cycles_1 - sc_mark), 64'd10);
        drv_flush[0] = 1'b1;
        step();
        drv_flush[0] = 1'b0;
        repeat (3) step();
        check_eq("stats_after_flush", 64'(bus0.stall_cycles_1), 64'(m_sc[0]));
`endif

        // Randomised traffic on both lanes of dut0.
        reset_dut();
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < 2; k++) begin
                drv_valid[k] = ($urandom_range(0, 99) < 55);
                drv_data[k]  = $urandom;
                drv_ready[k] = ($urandom_range(0, 99) < 70);
                drv_flush[k] = ($urandom_range(0, 39) == 0);
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
